mips_multicycle_control: RTL
============================

// Module: mips_multicycle_control
// PURPOSE
//  Multicycle MIPS control FSM. It is the issuing side of the registered ALU interface: it drives
//  the 4-bit ALU operation and the operand-mux selects, and consumes the registered zero flag.
//  It sequences fetch/decode/execute/memory/writeback for the datapath.
//  The ALU registers result/zero one cycle after issue, so every ALU use is an issue state plus a wait state.
// PARAMETERS
//  ILLEGAL_HALT  0  1: illegal instruction parks FSM in IDLE until reset; 0: pulse flag, continue
// PORTS
//  clk            in   1  system clock, all state updates on posedge
//  reset          in   1  asynchronous, active-high; forces IDLE
//  enable         in   1  permits start of a new instruction fetch
//  opcode         in   6  IR[31:26], valid from DECODE onward
//  funct          in   6  IR[5:0], valid from DECODE onward
//  alu_zero       in   1  registered ALU zero flag (data0==data1, independent of op)
//  alu_operation  out  4  AND=0 OR=1 ADD=2 SUB=6 MIN=7 NOR=12
//  alu_src_a      out  1  0=PC, 1=regA
//  alu_src_b      out  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  pc_src         out  2  0=ALU result, 1=branch target reg, 2=jump {PC[31:28],IR[25:0],2'b00}
//  pc_write       out  1  PC load enable
//  ir_write       out  1  IR load enable
//  iord           out  1  memory address: 0=PC, 1=ALU result
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe
//  reg_write      out  1  register file write enable
//  reg_dst        out  1  0=rt, 1=rd
//  mem_to_reg     out  1  0=ALU result, 1=memory data
//  target_write   out  1  latch ALU result into branch target register
//  instr_done     out  1  1-cycle pulse in final state of each instruction
//  illegal_instr  out  1  1-cycle pulse in DECODE_W on unsupported opcode/funct
//  state          out  4  current state encoding (debug)
// BEHAVIOUR
//  - States (4-bit): IDLE0 FETCH1 FETCH_W2 DECODE3 DECODE_W4 EXEC_R5 EXEC_I6 EXEC_W7 WB8 MEM_RD9
//    MEM_WB10 MEM_WR11 BRANCH12 BRANCH_W13 JUMP14. Code 15 goes to IDLE next cycle.
//  - Reset (async) -> IDLE. Every output is 0 in IDLE; state=0. Reset mid-instruction abandons it.
//    Strobes drop in the same cycle.
//  - Outputs are Moore-decoded from state. The only exception is pc_write in BRANCH_W (=alu_zero).
//  - Each *_W state repeats the operation and operand selects of its issue state, so the ALU
//    result stays valid during the following state. Non-ALU states drive operation=0, selects=0.
//  - IDLE: -> FETCH if enable.
//  - FETCH: mem_read, ir_write, iord=0, a=PC, b=4, ADD -> FETCH_W.
//  - FETCH_W: pc_write, pc_src=0 -> DECODE.
//  - DECODE: a=PC, b=imm<<2, ADD -> DECODE_W.
//  - DECODE_W: target_write, then dispatch on opcode:
//      0x00 with legal funct -> EXEC_R; 0x23/0x2B/0x08 -> EXEC_I; 0x04 -> BRANCH; 0x02 -> JUMP;
//      anything else -> illegal_instr, then FETCH/IDLE per enable (IDLE if ILLEGAL_HALT=1).
//  - Funct map: 0x24 -> 0; 0x25 -> 1; 0x20,0x21 -> 2; 0x22,0x23 -> 6; 0x2A -> 7; 0x27 -> 12;
//    all other functs are illegal.
//  - EXEC_R: a=regA, b=regB, op=funct map. EXEC_I: a=regA, b=imm, ADD. Both -> EXEC_W.
//  - EXEC_W: R/addi -> WB; lw -> MEM_RD; sw -> MEM_WR.
//  - WB: reg_write, mem_to_reg=0, reg_dst=1 for R-type, 0 for addi.
//  - MEM_RD: mem_read, iord=1 -> MEM_WB. MEM_WB: reg_write, reg_dst=0, mem_to_reg=1.
//  - MEM_WR: mem_write, iord=1.
//  - BRANCH: a=regA, b=regB, SUB -> BRANCH_W. BRANCH_W: pc_write=alu_zero, pc_src=1.
//  - JUMP: pc_write, pc_src=2.
//  - Final states are WB, MEM_WB, MEM_WR, BRANCH_W, JUMP and illegal DECODE_W. Each asserts
//    instr_done, then goes to FETCH if enable, else IDLE.
//  - enable is sampled only in IDLE and in final states. Deasserting it mid-instruction does not stall.
//  - Latency from FETCH entry: j 5, beq 6, R/addi/sw 7, lw 8 cycles.
// STRUCTURE
//  - Package mips_ctrl_pkg holds ALU op codes, opcode/funct constants, state encoding, and the
//    alu_src_b/pc_src select encodings.
//  - Sub-module alu_op_decode: combinational funct -> {operation, legal}.
//  - The rest is one state register plus next-state and output case blocks.
// TESTING
//  - Reset while in MEM_WR -> same cycle mem_write=0, state=0; stays IDLE until enable=1.
//  - enable=1, opcode=0x00, funct=0x20 -> states 1,2,3,4,5,7,8; operation=2 in 5 and 7;
//    reg_write=1, reg_dst=1 in 8; instr_done in 8.
//  - opcode=0x23 -> 8-cycle path ending in MEM_WB: mem_read+iord=1 in 9; reg_write+mem_to_reg=1 in 10.
//  - opcode=0x04, alu_zero=1 in BRANCH_W -> pc_write=1, pc_src=1;
//    repeat with alu_zero=0 -> pc_write=0, next state FETCH.
//  - opcode=0x00, funct=0x30 -> illegal_instr pulse in DECODE_W, no reg_write/mem_write.
//    ILLEGAL_HALT=1 -> IDLE held despite enable=1.
//  - enable=0 during a final state -> IDLE, all outputs 0; re-assert -> FETCH next cycle;
//    force state 15 -> IDLE next cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU ops, opcodes,
// funct codes, FSM states and the datapath mux select values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_MIN = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Code 15 is deliberately unnamed; the FSM recovers from it via its default arm.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_FETCH_W  = 4'd2,
    S_DECODE   = 4'd3,
    S_DECODE_W = 4'd4,
    S_EXEC_R   = 4'd5,
    S_EXEC_I   = 4'd6,
    S_EXEC_W   = 4'd7,
    S_WB       = 4'd8,
    S_MEM_RD   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_MEM_WR   = 4'd11,
    S_BRANCH   = 4'd12,
    S_BRANCH_W = 4'd13,
    S_JUMP     = 4'd14
  } state_e;

  typedef enum logic [1:0] {
    SRCB_REGB   = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_TARGET = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational R-type funct decoder: yields the ALU operation and whether
// the funct is one this control unit supports.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] operation,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    operation = ALU_AND;
    legal     = 1'b1;
    case (funct)
      FN_AND:           operation = ALU_AND;
      FN_OR:            operation = ALU_OR;
      FN_ADD, FN_ADDU:  operation = ALU_ADD;
      FN_SUB, FN_SUBU:  operation = ALU_SUB;
      FN_SLT:           operation = ALU_MIN;
      FN_NOR:           operation = ALU_NOR;
      default:          legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM driving a registered ALU: every ALU use is an
// issue state followed by a wait state that holds the same op and selects.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic [3:0] alu_operation,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       target_write,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       halt_q, halt_d;
  logic [3:0] r_op;
  logic       funct_legal;
  logic       is_rtype, is_mem_or_addi, instr_legal;
  state_e     after_final;

  alu_op_decode u_alu_op_decode (
    .funct     (funct),
    .operation (r_op),
    .legal     (funct_legal)
  );

  assign is_rtype       = (opcode == OP_RTYPE);
  assign is_mem_or_addi = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_ADDI);
  assign instr_legal    = (is_rtype && funct_legal) || is_mem_or_addi ||
                          (opcode == OP_BEQ) || (opcode == OP_J);
  assign after_final    = enable ? S_FETCH : S_IDLE;
  assign state          = state_q;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    halt_d  = halt_q;
    case (state_q)
      S_IDLE:     state_d = (enable && !halt_q) ? S_FETCH : S_IDLE;
      S_FETCH:    state_d = S_FETCH_W;
      S_FETCH_W:  state_d = S_DECODE;
      S_DECODE:   state_d = S_DECODE_W;
      S_DECODE_W: begin
        if (is_rtype && funct_legal) state_d = S_EXEC_R;
        else if (is_mem_or_addi)     state_d = S_EXEC_I;
        else if (opcode == OP_BEQ)   state_d = S_BRANCH;
        else if (opcode == OP_J)     state_d = S_JUMP;
        else if (ILLEGAL_HALT) begin
          state_d = S_IDLE;
          halt_d  = 1'b1;
        end else                     state_d = after_final;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_EXEC_W;
      S_EXEC_W: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_WB;
      end
      S_MEM_RD:   state_d = S_MEM_WB;
      S_BRANCH:   state_d = S_BRANCH_W;
      S_WB, S_MEM_WB, S_MEM_WR, S_BRANCH_W, S_JUMP: state_d = after_final;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_operation = ALU_AND;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_src        = PCSRC_ALU;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    target_write  = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH, S_FETCH_W: begin
        alu_operation = ALU_ADD;
        alu_src_b     = SRCB_FOUR;
        mem_read      = (state_q == S_FETCH);
        ir_write      = (state_q == S_FETCH);
        pc_write      = (state_q == S_FETCH_W);
      end
      S_DECODE, S_DECODE_W: begin
        alu_operation = ALU_ADD;
        alu_src_b     = SRCB_IMM_SH;
        if (state_q == S_DECODE_W) begin
          target_write  = 1'b1;
          illegal_instr = !instr_legal;
          instr_done    = !instr_legal;
        end
      end
      S_EXEC_R: begin
        alu_operation = r_op;
        alu_src_a     = 1'b1;
      end
      S_EXEC_I: begin
        alu_operation = ALU_ADD;
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
      end
      // The wait state re-issues whichever operation EXEC_R/EXEC_I started.
      S_EXEC_W: begin
        alu_operation = is_rtype ? r_op : ALU_ADD;
        alu_src_a     = 1'b1;
        alu_src_b     = is_rtype ? SRCB_REGB : SRCB_IMM;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        instr_done = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH, S_BRANCH_W: begin
        alu_operation = ALU_SUB;
        alu_src_a     = 1'b1;
        if (state_q == S_BRANCH_W) begin
          pc_write   = alu_zero;
          pc_src     = PCSRC_TARGET;
          instr_done = 1'b1;
        end
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
